// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART types and constants: FSM state encoding, line
//            levels and the baud divider helper (also used by uart_rx).
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Transmit FSM states; encodings 6 and 7 are unreachable
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    BITS   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    ACK    = 3'd5
  } uart_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Clock cycles per bit, truncated (100e6/19200 -> 5208)
  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_timer
// Brief    : Free-running bit-period counter. tick pulses for one cycle every
//            DIV cycles; clr restarts the period from zero.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_timer #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: wrap at the end of a bit period or restart on clear
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr || (cnt_q == LAST)) cnt_d = '0;
  end

  // Counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // tick depends only on the register so the FSM can use it to form clr
  assign tick = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : UART transmitter. Frames a latched byte as start/data[/parity]/
//            stop, LSB first, with a level send/tx_done handshake.
//            Optional feature macro: UART_TX_PARITY_EN (even parity bit).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 19_200,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] din,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  import uart_pkg::*;

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int CW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [CW-1:0]        bitcnt_q, bitcnt_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tick;
  logic                 clr;

  // Every state change restarts the bit period
  assign clr = (state_d != state_q);

  uart_baud_timer #(
    .DIV (BAUD_DIV)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .tick    (tick)
  );

  // Next-state logic: latch data on start, shift one bit per period
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    par_d    = par_q;
    case (state_q)
      IDLE: begin
        if (send) begin
          shreg_d  = din;
          par_d    = ^din;
          bitcnt_d = '0;
          state_d  = START;
        end
      end
      START: if (tick) state_d = BITS;
      BITS: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bitcnt_q == LAST_BIT) begin
            bitcnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d  = PARITY;
`else
            state_d  = STOP;
`endif
          end else begin
            bitcnt_d = bitcnt_q + CW'(1);
          end
        end
      end
      PARITY:  if (tick) state_d = STOP;
      STOP:    if (tick) state_d = ACK;
      ACK:     if (!send) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current state; registered below so tx never glitches
  always_comb begin
    tx_d   = IDLE_LEVEL;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      START: begin
        tx_d   = START_LEVEL;
        busy_d = 1'b1;
      end
      BITS: begin
        tx_d   = shreg_q[0];
        busy_d = 1'b1;
      end
      PARITY: begin
        tx_d   = par_q;
        busy_d = 1'b1;
      end
      STOP:    busy_d = 1'b1;
      ACK:     done_d = 1'b1;
      default: tx_d   = IDLE_LEVEL;
    endcase
  end

  // FSM, shift register and bit counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      par_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      par_q    <= par_d;
    end
  end

  // Output registers; reset forces the line idle immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_q   <= IDLE_LEVEL;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Self-checking bench for uart_tx (CLK_FREQ=16, BAUD=1 -> 16
//            cycles per bit). Honours UART_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NPER = 11;
`else
  localparam int NPER = 10;
`endif
  localparam int FLEN = NPER * DIV;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       send = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx;
  logic       busy;
  logic       tx_done;

  int checks = 0;
  int errors = 0;

  uart_tx #(
    .CLK_FREQ  (16),
    .BAUD      (1),
    .DATA_BITS (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .send    (send),
    .din     (din),
    .tx      (tx),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;       // byte presented at frame start
    logic       par;        // hand-computed even parity of data
    int         chg_cycle;  // frame cycle at which din is overwritten
    logic [7:0] chg_val;
    int         drop_at;    // frame cycle at which send is released
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, req);
    end
  endtask

  function automatic logic level(input vec_t v, input int p);
    logic [7:0] t;
    if (p == 0) return 1'b0;
    if (p <= 8) begin
      t = v.data >> (p - 1);
      return t[0];
    end
`ifdef UART_TX_PARITY_EN
    if (p == 9) return v.par;
`endif
    return 1'b1;
  endfunction

  // Entry: time is just after a rising edge, send already high, DUT idle
  task automatic check_frame(input vec_t v, input int id);
    int bad;
    int busy_cnt;
    int cyc;
    @(posedge clk); #1;
    chk($sformatf("v%0d_lat_tx", id), {31'd0, tx}, 32'd1);
    chk($sformatf("v%0d_lat_busy", id), {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    busy_cnt = 0;
    for (int p = 0; p < NPER; p++) begin
      bad = 0;
      for (int c = 0; c < DIV; c++) begin
        cyc = p * DIV + c;
        if (cyc > 0) begin
          @(posedge clk); #1;
        end
        if (tx !== level(v, p)) bad++;
        if (busy === 1'b1) busy_cnt++;
        if (cyc == v.chg_cycle) din = v.chg_val;
        if (cyc == v.drop_at) send = 1'b0;
      end
      chk($sformatf("v%0d_period%0d_bad_cycles", id, p), bad, 0);
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d_end_busy", id), {31'd0, busy}, 32'd0);
    chk($sformatf("v%0d_end_done", id), {31'd0, tx_done}, 32'd1);
    chk($sformatf("v%0d_end_tx", id), {31'd0, tx}, 32'd1);
    chk($sformatf("v%0d_busy_len", id), busy_cnt, FLEN);
    if (v.drop_at < FLEN) begin
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_clear", id), {31'd0, tx_done}, 32'd0);
    end else begin
      bad = 0;
      for (int c = FLEN + 1; c <= v.drop_at; c++) begin
        @(posedge clk); #1;
        if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b1) bad++;
      end
      chk($sformatf("v%0d_ack_dwell_bad", id), bad, 0);
      send = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_hold", id), {31'd0, tx_done}, 32'd1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_clear", id), {31'd0, tx_done}, 32'd0);
    end
  endtask

  initial begin
    int bad;
    vecs[0] = '{data: 8'hA5, par: 1'b0, chg_cycle: -1, chg_val: 8'h00, drop_at: 400};
    vecs[1] = '{data: 8'h3C, par: 1'b0, chg_cycle: 40, chg_val: 8'hFF, drop_at: 20};
    vecs[2] = '{data: 8'h07, par: 1'b1, chg_cycle: -1, chg_val: 8'h00, drop_at: 200};
    vecs[3] = '{data: 8'h03, par: 1'b0, chg_cycle: -1, chg_val: 8'h00, drop_at: 1};
    vecs[4] = '{data: 8'h5A, par: 1'b0, chg_cycle: 100, chg_val: 8'h00, drop_at: 30};

    // Reset held with send asserted: outputs stay idle
    reset_n = 1'b0;
    send    = 1'b1;
    din     = vecs[0].data;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    chk("reset_hold_bad_cycles", bad, 0);
    reset_n = 1'b1;
    check_frame(vecs[0], 0);

    for (int i = 1; i < 4; i++) begin
      repeat (3) @(posedge clk);
      #1;
      din  = vecs[i].data;
      send = 1'b1;
      check_frame(vecs[i], i);
    end

    // Reset asserted 70 cycles into a frame
    repeat (3) @(posedge clk);
    #1;
    din  = 8'hA5;
    send = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    repeat (70) @(posedge clk);
    #1;
    chk("midrst_pre_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    send    = 1'b0;
    #1;
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, tx_done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_idle_tx", {31'd0, tx}, 32'd1);
    din  = vecs[4].data;
    send = 1'b1;
    check_frame(vecs[4], 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
